// File: rtl/fifo_pkg.sv
// Shared constants and FSM state type for the read side of the 4-bit async FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 4;
  localparam int FIFO_ADDR_WIDTH = 4;

  localparam logic [FIFO_DATA_WIDTH-1:0] PAD_NIBBLE_DEFAULT = 4'h0;

  typedef enum logic [2:0] {
    FETCH_LO,
    WAIT_LO,
    FETCH_HI,
    WAIT_HI,
    OUT
  } pack_state_e;

endpackage

// File: rtl/fifo_nibble_packer_if.sv
// FIFO read port plus byte valid/ready port of the nibble packer; master is the packer side.
interface fifo_nibble_packer_if #(
  parameter int DATA_WIDTH = 4
) ();

  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   fifo_rdata;
  logic                    fifo_rinc;

  logic [2*DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_partial;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_rinc,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_partial
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_rinc,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_partial
  );

endinterface

// File: rtl/fifo_nibble_packer.sv
// Pops nibbles from the async FIFO read port, packs pairs into bytes and offers them on
// a valid/ready port; flush lets a lone first nibble out padded with PAD_NIBBLE.
module fifo_nibble_packer
  import fifo_pkg::*;
#(
  parameter int                    DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int                    RD_LATENCY = 1,
  parameter bit                    LO_FIRST   = 1'b1,
  parameter logic [DATA_WIDTH-1:0] PAD_NIBBLE = DATA_WIDTH'(PAD_NIBBLE_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  fifo_nibble_packer_if.master bus,
  output logic [7:0]           byte_count
);

  // RD_LATENCY is 1 or 2, so a single bit covers the wait counter.
  localparam logic LAT_LAST = 1'(RD_LATENCY - 1);

  pack_state_e             state_q, state_d;
  logic                    lat_q, lat_d;
  logic [DATA_WIDTH-1:0]   first_q, first_d;
  logic [2*DATA_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    partial_q, partial_d;
  logic [7:0]              count_q, count_d;
  logic                    pop;

  function automatic logic [2*DATA_WIDTH-1:0] pack(input logic [DATA_WIDTH-1:0] first,
                                                   input logic [DATA_WIDTH-1:0] second);
    return LO_FIRST ? {second, first} : {first, second};
  endfunction

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    pop       = ((state_q == FETCH_LO) || (state_q == FETCH_HI)) && !bus.fifo_empty;
    state_d   = state_q;
    lat_d     = lat_q;
    first_d   = first_q;
    data_d    = data_q;
    valid_d   = valid_q;
    partial_d = partial_q;
    count_d   = count_q;

    unique case (state_q)
      FETCH_LO: begin
        if (pop) begin
          state_d = WAIT_LO;
          lat_d   = 1'b0;
        end
      end
      WAIT_LO: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_LAST) begin
          first_d = bus.fifo_rdata;
          state_d = FETCH_HI;
        end
      end
      FETCH_HI: begin
        // A pop outranks flush so a nibble already in the FIFO is never padded away.
        if (pop) begin
          state_d = WAIT_HI;
          lat_d   = 1'b0;
        end else if (flush) begin
          data_d    = pack(first_q, PAD_NIBBLE);
          partial_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = OUT;
        end
      end
      WAIT_HI: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_LAST) begin
          data_d    = pack(first_q, bus.fifo_rdata);
          partial_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          count_d = count_q + 8'd1;
          state_d = FETCH_LO;
        end
      end
      default: state_d = FETCH_LO;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH_LO;
      lat_q     <= 1'b0;
      first_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      partial_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      first_q   <= first_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      partial_q <= partial_d;
      count_q   <= count_d;
    end
  end

  assign bus.fifo_rinc   = pop;
  assign bus.out_data    = data_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_partial = partial_q;
  assign byte_count      = count_q;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer: dut0 (RD_LATENCY=1, LO_FIRST=1) and dut1 (RD_LATENCY=2,
// LO_FIRST=0), each fed by a queue-based FIFO model, bytes compared against a pairing model.
module tb_fifo_nibble_packer;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush0, flush1;
  logic [7:0] bc0, bc1;
  logic       push_req [2];
  logic [3:0] push_val [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int empty_viol = 0;
  int pops0[$], pops1[$], vcyc0[$], vcyc1[$];
  logic [8:0] got0[$], got1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_nibble_packer_if #(.DATA_WIDTH(4)) if0 ();
  fifo_nibble_packer_if #(.DATA_WIDTH(4)) if1 ();

  fifo_nibble_packer #(.DATA_WIDTH(4), .RD_LATENCY(1), .LO_FIRST(1'b1), .PAD_NIBBLE(4'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0), .bus(if0), .byte_count(bc0));
  fifo_nibble_packer #(.DATA_WIDTH(4), .RD_LATENCY(2), .LO_FIRST(1'b0), .PAD_NIBBLE(4'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(if1), .byte_count(bc1));

  // FIFO model: data visible LAT cycles after the pop edge, empty flag registered.
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [3:0] q[$];
    logic       empty_r;
    logic [3:0] p0, p1;
    logic       rinc_w;
    assign rinc_w = (g == 0) ? if0.fifo_rinc : if1.fifo_rinc;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        empty_r <= 1'b1;
        p0 <= '0;
        p1 <= '0;
      end else begin
        if (rinc_w && q.size() > 0) p0 <= q.pop_front();
        p1 <= p0;
        if (push_req[g]) q.push_back(push_val[g]);
        empty_r <= (q.size() == 0);
      end
    end
  end

  assign if0.fifo_empty = g_fifo[0].empty_r;
  assign if0.fifo_rdata = g_fifo[0].p0;
  assign if1.fifo_empty = g_fifo[1].empty_r;
  assign if1.fifo_rdata = g_fifo[1].p1;

  always @(negedge clk) begin
    if (if0.fifo_rinc) pops0.push_back(cyc);
    if (if1.fifo_rinc) pops1.push_back(cyc);
    if (if0.out_valid) vcyc0.push_back(cyc);
    if (if1.out_valid) vcyc1.push_back(cyc);
    if (if0.out_valid && if0.out_ready) got0.push_back({if0.out_partial, if0.out_data});
    if (if1.out_valid && if1.out_ready) got1.push_back({if1.out_partial, if1.out_data});
    if ((if0.fifo_rinc && if0.fifo_empty) || (if1.fifo_rinc && if1.fifo_empty))
      empty_viol <= empty_viol + 1;
  end

  // Reference: the n-th byte is built from the (2n)-th and (2n+1)-th pushed nibbles.
  function automatic logic [8:0] exp_byte(input logic [3:0] first, input logic [3:0] second,
                                          input bit lo_first, input bit partial);
    int lo, hi;
    if (partial) second = 4'h0;
    lo = lo_first ? int'(first) : int'(second);
    hi = lo_first ? int'(second) : int'(first);
    return {partial, 8'(hi * 16 + lo)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int g, input logic [3:0] v);
    push_req[g] = 1'b1;
    push_val[g] = v;
    step();
    push_req[g] = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    flush0 = 1'b0;
    flush1 = 1'b0;
    push_req[0] = 1'b0;
    push_req[1] = 1'b0;
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_bytes(input int g, input int n, input int budget, input string tag);
    int k = 0;
    while (((g == 0) ? got0.size() : got1.size()) < n && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (((g == 0) ? got0.size() : got1.size()) < n) begin
      n_fail++;
      $display("FAIL %s_timeout: bytes seen %0d, required %0d within %0d cycles", tag,
               (g == 0) ? got0.size() : got1.size(), n, budget);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if0.out_valid); end
    n_checks++; if (if0.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", if0.out_data); end
    n_checks++; if (if0.out_partial !== 1'b0) begin n_fail++; $display("FAIL reset_partial: got %b want 0", if0.out_partial); end
    n_checks++; if (bc0 !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bc0); end
    n_checks++; if (if0.fifo_rinc !== 1'b0) begin n_fail++; $display("FAIL reset_rinc: got %b want 0", if0.fifo_rinc); end
    n_checks++; if (dut0.state_q !== FETCH_LO) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut0.state_q, FETCH_LO); end
    n_checks++; if (if1.out_valid !== 1'b0 || bc1 !== 8'd0) begin n_fail++; $display("FAIL reset_dut1: valid %b count %0d want 0/0", if1.out_valid, bc1); end
  endtask

  task automatic test_basic();
    int pb, vb, gb;
    apply_reset();
    pb = pops0.size(); vb = vcyc0.size(); gb = got0.size();
    if0.out_ready = 1'b1;
    push(0, 4'h3);
    push(0, 4'hA);
    wait_bytes(0, gb + 1, 30, "basic");
    repeat (3) step();
    n_checks++; if (pops0.size() - pb != 2) begin n_fail++; $display("FAIL basic_pops: got %0d want 2", pops0.size() - pb); end
    n_checks++; if (vcyc0.size() - vb != 1) begin n_fail++; $display("FAIL basic_valid_len: got %0d want 1", vcyc0.size() - vb); end
    if (pops0.size() > pb && vcyc0.size() > vb) begin
      n_checks++;
      if (vcyc0[vb] - pops0[pb] != 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", vcyc0[vb] - pops0[pb]); end
    end
    if (got0.size() > gb) begin
      n_checks++;
      if (got0[gb] !== exp_byte(4'h3, 4'hA, 1'b1, 1'b0)) begin n_fail++; $display("FAIL basic_byte: got %h want %h", got0[gb], exp_byte(4'h3, 4'hA, 1'b1, 1'b0)); end
    end
    n_checks++; if (bc0 !== 8'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", bc0); end
  endtask

  task automatic test_backpressure();
    int gb, pb, k;
    logic [3:0] nib [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    apply_reset();
    gb = got0.size();
    for (int i = 0; i < 4; i++) push(0, nib[i]);
    k = 0;
    while (!if0.out_valid && k < 20) begin step(); k++; end
    n_checks++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b want 1", if0.out_valid); end
    pb = pops0.size();
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (if0.out_data !== exp_byte(nib[0], nib[1], 1'b1, 1'b0) || if0.out_valid !== 1'b1)
        begin n_fail++; $display("FAIL bp_hold: cycle %0d data %h valid %b want 21/1", i, if0.out_data, if0.out_valid); end
    end
    n_checks++; if (pops0.size() != pb) begin n_fail++; $display("FAIL bp_no_pop: got %0d pops want 0", pops0.size() - pb); end
    if0.out_ready = 1'b1;
    wait_bytes(0, gb + 2, 30, "bp");
    step();
    for (int i = 0; i < 2; i++)
      if (got0.size() > gb + i) begin
        n_checks++;
        if (got0[gb + i] !== exp_byte(nib[2 * i], nib[2 * i + 1], 1'b1, 1'b0))
          begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, got0[gb + i], exp_byte(nib[2 * i], nib[2 * i + 1], 1'b1, 1'b0)); end
      end
    n_checks++; if (bc0 !== 8'd2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", bc0); end
  endtask

  task automatic test_flush();
    int gb, pb, vb;
    apply_reset();
    gb = got0.size(); pb = pops0.size(); vb = vcyc0.size();
    if0.out_ready = 1'b1;
    push(0, 4'h5);
    repeat (20) step();
    n_checks++; if (dut0.state_q !== FETCH_HI) begin n_fail++; $display("FAIL flush_stall_state: got %0d want %0d", dut0.state_q, FETCH_HI); end
    n_checks++; if (vcyc0.size() != vb || pops0.size() - pb != 1) begin n_fail++; $display("FAIL flush_stall_io: valids %0d pops %0d want 0/1", vcyc0.size() - vb, pops0.size() - pb); end
    flush0 = 1'b1;
    wait_bytes(0, gb + 1, 10, "flush");
    flush0 = 1'b0;
    step();
    if (got0.size() > gb) begin
      n_checks++;
      if (got0[gb] !== exp_byte(4'h5, 4'h0, 1'b1, 1'b1)) begin n_fail++; $display("FAIL flush_byte: got %h want %h", got0[gb], exp_byte(4'h5, 4'h0, 1'b1, 1'b1)); end
    end
    n_checks++; if (bc0 !== 8'd1) begin n_fail++; $display("FAIL flush_count: got %0d want 1", bc0); end
  endtask

  task automatic test_empty_gap();
    int gb;
    apply_reset();
    gb = got0.size();
    if0.out_ready = 1'b1;
    push(0, 4'h7);
    repeat (15) step();
    push(0, 4'h9);
    wait_bytes(0, gb + 1, 20, "gap");
    repeat (8) step();
    n_checks++; if (got0.size() - gb != 1) begin n_fail++; $display("FAIL gap_nbytes: got %0d want 1", got0.size() - gb); end
    if (got0.size() > gb) begin
      n_checks++;
      if (got0[gb] !== exp_byte(4'h7, 4'h9, 1'b1, 1'b0)) begin n_fail++; $display("FAIL gap_byte: got %h want %h", got0[gb], exp_byte(4'h7, 4'h9, 1'b1, 1'b0)); end
    end
  endtask

  task automatic test_reset_mid();
    int gb, k;
    apply_reset();
    gb = got0.size();
    if0.out_ready = 1'b1;
    push(0, 4'h1);
    push(0, 4'h2);
    wait_bytes(0, gb + 1, 20, "rmid_pre");
    push(0, 4'hE);
    k = 0;
    while (dut0.state_q !== WAIT_LO && k < 10) begin step(); k++; end
    n_checks++; if (dut0.state_q !== WAIT_LO || bc0 !== 8'd1) begin n_fail++; $display("FAIL rmid_setup: state %0d count %0d want %0d/1", dut0.state_q, bc0, WAIT_LO); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (dut0.state_q !== FETCH_LO) begin n_fail++; $display("FAIL rmid_state: got %0d want %0d", dut0.state_q, FETCH_LO); end
    n_checks++; if (if0.out_valid !== 1'b0 || bc0 !== 8'd0) begin n_fail++; $display("FAIL rmid_outputs: valid %b count %0d want 0/0", if0.out_valid, bc0); end
    step();
    step();
    rst_n = 1'b1;
    step();
    gb = got0.size();
    push(0, 4'hC);
    push(0, 4'hD);
    wait_bytes(0, gb + 1, 20, "rmid_post");
    step();
    if (got0.size() > gb) begin
      n_checks++;
      if (got0[gb] !== exp_byte(4'hC, 4'hD, 1'b1, 1'b0)) begin n_fail++; $display("FAIL rmid_byte: got %h want %h", got0[gb], exp_byte(4'hC, 4'hD, 1'b1, 1'b0)); end
    end
    n_checks++; if (bc0 !== 8'd1) begin n_fail++; $display("FAIL rmid_count: got %0d want 1", bc0); end
  endtask

  task automatic test_wrap_random();
    logic [3:0] nibs [512];
    int gb;
    apply_reset();
    gb = got0.size();
    for (int i = 0; i < 512; i++) nibs[i] = 4'($urandom_range(0, 15));
    fork
      begin
        for (int i = 0; i < 512; i++) begin
          push(0, nibs[i]);
          if ($urandom_range(0, 3) == 0) step();
        end
      end
      begin
        int k = 0;
        while (got0.size() < gb + 256 && k < 8000) begin
          if0.out_ready = ($urandom_range(0, 3) != 0);
          step();
          k++;
        end
      end
    join
    if0.out_ready = 1'b1;
    wait_bytes(0, gb + 256, 100, "wrap");
    step();
    for (int i = 0; i < 256; i++)
      if (got0.size() > gb + i) begin
        n_checks++;
        if (got0[gb + i] !== exp_byte(nibs[2 * i], nibs[2 * i + 1], 1'b1, 1'b0))
          begin n_fail++; $display("FAIL wrap_byte%0d: got %h want %h", i, got0[gb + i], exp_byte(nibs[2 * i], nibs[2 * i + 1], 1'b1, 1'b0)); end
      end
    n_checks++; if (bc0 !== 8'd0) begin n_fail++; $display("FAIL wrap_count: got %0d want 0", bc0); end
  endtask

  task automatic test_hi_first_lat2();
    int gb, pb, vb, k;
    apply_reset();
    gb = got1.size(); pb = pops1.size(); vb = vcyc1.size();
    if1.out_ready = 1'b1;
    push(1, 4'h3);
    push(1, 4'hA);
    wait_bytes(1, gb + 1, 30, "hi_first");
    step();
    if (got1.size() > gb) begin
      n_checks++;
      if (got1[gb] !== exp_byte(4'h3, 4'hA, 1'b0, 1'b0)) begin n_fail++; $display("FAIL hi_first_byte: got %h want %h", got1[gb], exp_byte(4'h3, 4'hA, 1'b0, 1'b0)); end
    end
    if (pops1.size() > pb && vcyc1.size() > vb) begin
      n_checks++;
      if (vcyc1[vb] - pops1[pb] != 2 * (1 + 2)) begin n_fail++; $display("FAIL hi_first_latency: got %0d want 6", vcyc1[vb] - pops1[pb]); end
    end
    push(1, 4'h6);
    k = 0;
    while (dut1.state_q !== FETCH_HI && k < 10) begin step(); k++; end
    flush1 = 1'b1;
    wait_bytes(1, gb + 2, 10, "hi_first_flush");
    flush1 = 1'b0;
    step();
    if (got1.size() > gb + 1) begin
      n_checks++;
      if (got1[gb + 1] !== exp_byte(4'h6, 4'h0, 1'b0, 1'b1)) begin n_fail++; $display("FAIL hi_first_flush_byte: got %h want %h", got1[gb + 1], exp_byte(4'h6, 4'h0, 1'b0, 1'b1)); end
    end
    n_checks++; if (bc1 !== 8'd2) begin n_fail++; $display("FAIL hi_first_count: got %0d want 2", bc1); end
  endtask

  initial begin
    rst_n = 1'b0;
    flush0 = 1'b0;
    flush1 = 1'b0;
    push_req[0] = 1'b0;
    push_req[1] = 1'b0;
    push_val[0] = '0;
    push_val[1] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_empty_gap();
    test_reset_mid();
    test_wrap_random();
    test_hi_first_lat2();
    n_checks++;
    if (empty_viol != 0) begin n_fail++; $display("FAIL rinc_while_empty: got %0d cycles want 0", empty_viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
